counter_sweep_ctrl: RTL and testbench

//   Sequences a 3-bit up/down counter through a programmed triangle sweep:
//   lo -> hi -> lo, repeated `reps` times, under a start/busy/done handshake.

---
 rtl/counter_sweep_ctrl_pkg.sv | 13 +
 rtl/updown_counter_en.sv | 26 ++
 rtl/counter_sweep_ctrl.sv | 112 +++++++++++
 tb/tb_counter_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep controller: state encodings and
// default datapath widths.
package counter_sweep_ctrl_pkg;

  localparam int WIDTH_DEF  = 3;
  localparam int REPS_W_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/updown_counter_en.sv
// Loadable up/down counter with enable; load wins over enable.
module updown_counter_en
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle sweep sequencer: drives an up/down counter lo -> hi -> lo for a
// programmed number of repetitions, with pause and abort.
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int REPS_W = REPS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [REPS_W-1:0] reps,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic [1:0]        dbg_state
);

  // Handshake: start is sampled only in IDLE; an accepted start raises busy
  // on the next edge, busy stays high for the whole sweep, and done pulses for
  // exactly one cycle afterwards (aborted qualifies it). Starts seen while
  // busy or done are dropped, never queued.

  logic [1:0]        state;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  hi_q;
  logic [REPS_W-1:0] rep_left;
  logic              active;
  logic              accept;
  logic              reject;
  logic              step;
  logic [WIDTH-1:0]  cnt_up;
  logic [WIDTH-1:0]  cnt_dn;

  assign active = (state == S_UP) || (state == S_DOWN);
  assign accept = (state == S_IDLE) && start && (lo < hi);
  assign reject = (state == S_IDLE) && start && !(lo < hi);
  assign step   = active && !pause && !abort;
  assign cnt_up = count + WIDTH'(1);
  assign cnt_dn = count - WIDTH'(1);

  assign busy      = active;
  assign done      = (state == S_DONE);
  assign dir       = (state == S_UP);
  assign dbg_state = state;

  updown_counter_en #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (step),
    .load     (accept),
    .load_val (lo),
    .up_down  (state == S_UP),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      rep_left <= '0;
      aborted  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= reject;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lo_q     <= lo;
            hi_q     <= hi;
            rep_left <= (reps == '0) ? REPS_W'(1) : reps;
            aborted  <= 1'b0;
            state    <= S_UP;
          end
        end
        S_UP: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (!pause && cnt_up == hi_q) begin
            state <= S_DOWN;
          end
        end
        S_DOWN: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (!pause && cnt_dn == lo_q) begin
            // Last leg returns to lo; otherwise start the next repetition.
            if (rep_left == REPS_W'(1)) begin
              state <= S_DONE;
            end else begin
              rep_left <= rep_left - REPS_W'(1);
              state    <= S_UP;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl: a sweep/reject vector table plus
// hand-written pause, abort and reset sequences.
module tb_counter_sweep_ctrl;
  import counter_sweep_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] lo = '0;
  logic [2:0] hi = '0;
  logic [3:0] reps = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] count;
  logic       dir, busy, done, aborted, cfg_err;
  logic [1:0] dbg_state;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] reps;
    logic       exp_err;
    int         exp_edges;
  } vec_t;

  vec_t vecs[8];

  counter_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .reps(reps),
    .pause(pause), .abort(abort), .count(count), .dir(dir), .busy(busy),
    .done(done), .aborted(aborted), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_for(input logic [2:0] v, input logic [1:0] st, input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      if (count == v && dbg_state == st) break;
      tick();
    end
    chk({nm, " reach"}, int'(count == v && dbg_state == st), 1);
  endtask

  task automatic run_sweep(input logic [2:0] l, input logic [2:0] h,
                           input logic [3:0] r, input int exp_edges, input string nm);
    int lv, hv, rr, edges, busy_cyc;
    logic [3:0] e;
    lv = int'(l);
    hv = int'(h);
    rr = (r == 0) ? 1 : int'(r);
    exp_q.delete();
    exp_q.push_back({1'b1, l});
    for (int k = 0; k < rr; k++) begin
      for (int v = lv + 1; v <= hv; v++) exp_q.push_back({(v != hv), 3'(v)});
      for (int v = hv - 1; v >= lv; v--) exp_q.push_back({(v == lv && k != rr - 1), 3'(v)});
    end
    lo = l; hi = h; reps = r; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({nm, " count"}, int'(count), int'(e[2:0]));
        chk({nm, " dir"}, int'(dir), int'(e[3]));
      end
      if (done) break;
      if (busy) busy_cyc++;
      tick();
      edges++;
    end
    chk({nm, " edges_to_done"}, edges, exp_edges);
    chk({nm, " busy_cycles"}, busy_cyc, exp_edges - 1);
    chk({nm, " aborted"}, int'(aborted), 0);
    chk({nm, " busy_at_done"}, int'(busy), 0);
    tick();
    chk({nm, " done_one_cycle"}, int'(done), 0);
    chk({nm, " back_idle"}, int'(dbg_state), int'(S_IDLE));
  endtask

  task automatic run_reject(input logic [2:0] l, input logic [2:0] h, input string nm);
    logic [2:0] prev;
    prev = count;
    lo = l; hi = h; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, " cfg_err"}, int'(cfg_err), 1);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " count_held"}, int'(count), int'(prev));
    chk({nm, " state"}, int'(dbg_state), int'(S_IDLE));
    tick();
    chk({nm, " cfg_err_pulse"}, int'(cfg_err), 0);
    chk({nm, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int edges;
    vecs[0] = '{lo: 3'd2, hi: 3'd4, reps: 4'd1, exp_err: 1'b0, exp_edges: 5};
    vecs[1] = '{lo: 3'd0, hi: 3'd7, reps: 4'd2, exp_err: 1'b0, exp_edges: 29};
    vecs[2] = '{lo: 3'd5, hi: 3'd5, reps: 4'd1, exp_err: 1'b1, exp_edges: 0};
    vecs[3] = '{lo: 3'd6, hi: 3'd3, reps: 4'd1, exp_err: 1'b1, exp_edges: 0};
    vecs[4] = '{lo: 3'd1, hi: 3'd6, reps: 4'd0, exp_err: 1'b0, exp_edges: 11};
    vecs[5] = '{lo: 3'd3, hi: 3'd4, reps: 4'd1, exp_err: 1'b0, exp_edges: 3};
    vecs[6] = '{lo: 3'd6, hi: 3'd7, reps: 4'd3, exp_err: 1'b0, exp_edges: 7};
    vecs[7] = '{lo: 3'd0, hi: 3'd7, reps: 4'd1, exp_err: 1'b0, exp_edges: 15};

    // Clock/reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset count", int'(count), 0);
    chk("reset state", int'(dbg_state), int'(S_IDLE));
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset dir", int'(dir), 0);
    chk("reset aborted", int'(aborted), 0);
    chk("reset cfg_err", int'(cfg_err), 0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort state", int'(dbg_state), int'(S_IDLE));
    chk("idle_abort done", int'(done), 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_err)
        run_reject(vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i));
      else
        run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].reps, vecs[i].exp_edges,
                  $sformatf("vec%0d", i));
    end

    // Pause for three cycles at count=4 on the way up.
    lo = 3'd1; hi = 3'd6; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    for (int k = 0; k < 20 && count != 3'd4; k++) begin
      tick();
      edges++;
    end
    chk("pause reach4", int'(count), 4);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      edges++;
      chk("pause hold count", int'(count), 4);
      chk("pause hold state", int'(dbg_state), int'(S_UP));
    end
    pause = 1'b0;
    tick();
    edges++;
    chk("pause resume", int'(count), 5);
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      edges++;
    end
    chk("pause total_edges", edges, 14);
    chk("pause final count", int'(count), 1);
    tick();

    // Abort beats pause while counting down at 3; start during DONE dropped.
    lo = 3'd1; hi = 3'd5; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wait_for(3'd3, S_DOWN, "abort");
    pause = 1'b1;
    abort = 1'b1;
    tick();
    pause = 1'b0;
    abort = 1'b0;
    chk("abort done", int'(done), 1);
    chk("abort aborted", int'(aborted), 1);
    chk("abort count", int'(count), 3);
    chk("abort busy", int'(busy), 0);
    lo = 3'd0; hi = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done state", int'(dbg_state), int'(S_IDLE));
    chk("start_in_done count", int'(count), 3);
    tick();
    chk("start_in_done not_queued", int'(busy), 0);

    // Reset in the middle of a sweep.
    lo = 3'd2; hi = 3'd6; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("new_start aborted_cleared", int'(aborted), 0);
    wait_for(3'd4, S_UP, "rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst count", int'(count), 0);
    chk("midrst state", int'(dbg_state), int'(S_IDLE));
    chk("midrst busy", int'(busy), 0);
    chk("midrst dir", int'(dir), 0);
    for (int k = 0; k < 3; k++) begin
      chk("midrst no_done", int'(done), 0);
      tick();
    end
    chk("midrst idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
